// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

  localparam logic [3:0] ROW1 = 4'b1000;
  localparam logic [3:0] ROW2 = 4'b0100;
  localparam logic [3:0] ROW3 = 4'b0010;
  localparam logic [3:0] ROW4 = 4'b0001;

  function automatic logic onehot4(logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Row sequence 1000 -> 0100 -> 0010 -> 0001 -> 1000.
  function automatic logic [3:0] next_row(logic [3:0] r);
    return {r[0], r[3:1]};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin-side and decoded-key signals of the keypad scanner.
// slave: the scanner itself; master: whatever drives the column pins and consumes keys.
interface keypad_scanner_if;
  logic [3:0] col_in;
  logic [3:0] row_drive;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       key_valid;
  logic       key_held;

  modport master (output col_in,
                  input  row_drive, key_row, key_col, key_valid, key_held);
  modport slave  (input  col_in,
                  output row_drive, key_row, key_col, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchronizer for the asynchronous column pins.
module col_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 4'b0000;
      sync_q <= 4'b0000;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with single-key ownership, press/release debounce.
// Define KEYPAD_REPEAT_EN to get auto-repeat strobes while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4800,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REPEAT_CYCLES   = 24000000
) (
  input  logic            clk,
  input  logic            reset,
  keypad_scanner_if.slave kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  kp_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       lat_row_q, lat_row_d;
  logic [3:0]       lat_col_q, lat_col_d;
  logic [3:0]       key_row_q, key_row_d;
  logic [3:0]       key_col_q, key_col_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [3:0]       col_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_end;
  assign rep_end = (rep_cnt_q == REP_LAST);
`endif

  col_sync u_col_sync (.clk(clk), .reset(reset), .d(kp.col_in), .q(col_s));

  logic dwell_end, deb_end, lone_col, col_match, owned;
  assign dwell_end = (div_cnt_q == DIV_LAST);
  assign deb_end   = (deb_cnt_q == DEB_LAST);
  assign lone_col  = onehot4(col_s);
  assign col_match = (col_s == lat_col_q);
  assign owned     = |(col_s & lat_col_q);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= SCAN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:     if (dwell_end && lone_col) state_d = DEBOUNCE;
      DEBOUNCE: if (!col_match)            state_d = SCAN;
                else if (deb_end)          state_d = HELD;
      HELD:     if (!owned)                state_d = RELEASE;
      RELEASE:  if (owned)                 state_d = HELD;
                else if (deb_end)          state_d = SCAN;
      default:                             state_d = SCAN;
    endcase
  end

  // Row drive stays frozen outside SCAN so col_s keeps reading the owned row;
  // that freeze is what locks out every other key until release completes.
  always_comb begin
    div_cnt_d   = '0;
    deb_cnt_d   = deb_cnt_q;
    row_d       = row_q;
    lat_row_d   = lat_row_q;
    lat_col_d   = lat_col_q;
    key_row_d   = key_row_q;
    key_col_d   = key_col_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = '0;
`endif
    case (state_q)
      SCAN: begin
        if (!dwell_end) div_cnt_d = div_cnt_q + 1'b1;
        else if (lone_col) begin
          lat_row_d = row_q;
          lat_col_d = col_s;
          deb_cnt_d = '0;
        end else row_d = next_row(row_q);
      end
      DEBOUNCE: begin
        if (!col_match) row_d = next_row(row_q);
        else if (deb_end) begin
          key_valid_d = 1'b1;
          key_row_d   = lat_row_q;
          key_col_d   = lat_col_q;
          key_held_d  = 1'b1;
        end else deb_cnt_d = deb_cnt_q + 1'b1;
      end
      HELD: begin
        if (!owned) deb_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
        // Gate on key_valid_q so a 1-cycle repeat interval cannot strobe back to back.
        else if (rep_end) key_valid_d = !key_valid_q;
        else rep_cnt_d = rep_cnt_q + 1'b1;
`endif
      end
      RELEASE: begin
        if (!owned) begin
          if (deb_end) begin
            row_d      = next_row(row_q);
            key_row_d  = '0;
            key_col_d  = '0;
            key_held_d = 1'b0;
          end else deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      row_q       <= ROW1;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      key_row_q   <= '0;
      key_col_q   <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      div_cnt_q   <= div_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      row_q       <= row_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      key_row_q   <= key_row_d;
      key_col_q   <= key_col_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign kp.row_drive = row_q;
  assign kp.key_row   = key_row_q;
  assign kp.key_col   = key_col_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model feeds col_in from row_drive.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int DIV = 4;
  localparam int DEB = 8;
  localparam int REP = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset(reset), .kp(kp)
  );

  // pressed[r][c]: r 0 = row 1, c 0 = column 1.
  logic [3:0][3:0] pressed = '0;
  logic [3:0]      cols;
  always_comb begin
    cols = 4'b0000;
    for (int r = 0; r < 4; r++)
      if (kp.row_drive[3 - r]) cols = cols | pressed[r];
  end
  assign kp.col_in = cols;

  int vcount = 0;
  always @(negedge clk) if (kp.key_valid) vcount++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int bound, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!kp.key_valid && n < bound);
    check(name, 32'(kp.key_valid), 32'd1);
  endtask

  // Pin drop -> 2 sync edges -> 1 detect edge -> DEB release-debounce edges.
  task automatic release_key(input int r, input int c, input string name);
    int n;
    @(negedge clk);
    pressed[r][c] = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (kp.key_held && n < 40);
    check({name, "_release_lat"}, 32'(n), 32'(DEB + 3));
    check({name, "_cleared"}, 32'({kp.key_row, kp.key_col}), 32'h0);
  endtask

  typedef struct {
    int         r;
    int         c;
    logic [3:0] exp_row;
    logic [3:0] exp_col;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int n, vbase, nrep;
    int off [2];
    logic [3:0] exp_row, rows_seen;

    vecs[0] = '{r: 1, c: 2, exp_row: ROW2, exp_col: 4'b0100};
    vecs[1] = '{r: 0, c: 0, exp_row: ROW1, exp_col: 4'b0001};
    vecs[2] = '{r: 3, c: 3, exp_row: ROW4, exp_col: 4'b1000};
    vecs[3] = '{r: 2, c: 1, exp_row: ROW3, exp_col: 4'b0010};

    // Reset state
    tick(3);
    check("rst_row_drive", 32'(kp.row_drive), 32'h8);
    check("rst_key_row",   32'(kp.key_row),   32'h0);
    check("rst_key_col",   32'(kp.key_col),   32'h0);
    check("rst_key_valid", 32'(kp.key_valid), 32'h0);
    check("rst_key_held",  32'(kp.key_held),  32'h0);

    // Idle scan: row advances every DIV edges after reset release
    @(negedge clk); reset = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      exp_row = 4'b1000 >> ((k / DIV) % 4);
      check($sformatf("scan_row_k%0d", k), 32'(kp.row_drive), 32'(exp_row));
    end
    check("scan_no_strobe", 32'(vcount), 32'd0);

    // Press latency from reset: row 2 reached at edge 4, latched at 8, strobe at 8+DEB
    @(negedge clk); reset = 1'b0; pressed[1][2] = 1'b1;
    tick(2);
    @(negedge clk); reset = 1'b1;
    wait_valid("lat_valid", 40, n);
    check("press_latency", 32'(n), 32'd16);
    check("lat_key_row", 32'(kp.key_row), 32'(ROW2));
    check("lat_key_col", 32'(kp.key_col), 32'h4);
    tick(1);
    check("lat_one_cycle", 32'(kp.key_valid), 32'd0);
    release_key(1, 2, "lat");

    // Table of clean presses
    for (int i = 0; i < 4; i++) begin
      tick(3);
      @(negedge clk); pressed[vecs[i].r][vecs[i].c] = 1'b1;
      wait_valid($sformatf("v%0d_valid", i), 80, n);
      check($sformatf("v%0d_key_row", i), 32'(kp.key_row), 32'(vecs[i].exp_row));
      check($sformatf("v%0d_key_col", i), 32'(kp.key_col), 32'(vecs[i].exp_col));
      check($sformatf("v%0d_held", i), 32'(kp.key_held), 32'd1);
      tick(1);
      check($sformatf("v%0d_strobe_end", i), 32'(kp.key_valid), 32'd0);
      release_key(vecs[i].r, vecs[i].c, $sformatf("v%0d", i));
    end

    // Bounce: row 2 / column 3 toggling every 3 cycles never debounces
    vbase = vcount;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); pressed[1][2] = ~pressed[1][2];
      repeat (2) @(negedge clk);
    end
    pressed = '0;
    tick(12);
    check("bounce_no_strobe", 32'(vcount - vbase), 32'd0);
    check("bounce_not_held", 32'(kp.key_held), 32'd0);
    exp_row = kp.row_drive;
    n = 0;
    do begin tick(1); n++; end while (kp.row_drive == exp_row && n < 8);
    check("bounce_scan_resumes", 32'(kp.row_drive != exp_row), 32'd1);

    // Lockout: row 1 / column 1 owned, row 4 / column 2 pressed meanwhile
    @(negedge clk); pressed[0][0] = 1'b1;
    wait_valid("lock_valid", 80, n);
    check("lock_key_row", 32'(kp.key_row), 32'(ROW1));
    check("lock_key_col", 32'(kp.key_col), 32'h1);
    tick(2);
    vbase = vcount;
    @(negedge clk); pressed[3][1] = 1'b1;
    tick(20);
`ifdef KEYPAD_REPEAT_EN
    check("lock_strobes", 32'(vcount - vbase), 32'd1);
`else
    check("lock_strobes", 32'(vcount - vbase), 32'd0);
`endif
    check("lock_key_col_kept", 32'(kp.key_col), 32'h1);
    release_key(0, 0, "lock_r1");
    wait_valid("lock_r4_valid", 100, n);
    check("lock_r4_key_row", 32'(kp.key_row), 32'(ROW4));
    check("lock_r4_key_col", 32'(kp.key_col), 32'h2);
    release_key(3, 1, "lock_r4");

    // Two columns on row 3: never latched, scan keeps rotating
    vbase = vcount;
    rows_seen = 4'b0000;
    @(negedge clk); pressed[2] = 4'b0011;
    for (int i = 0; i < 48; i++) begin
      tick(1);
      rows_seen = rows_seen | kp.row_drive;
    end
    check("dual_no_strobe", 32'(vcount - vbase), 32'd0);
    check("dual_not_held", 32'(kp.key_held), 32'd0);
    check("dual_rows_seen", 32'(rows_seen), 32'hF);
    @(negedge clk); pressed = '0;
    tick(4);

    // Reset while HELD clears everything on the next edge
    @(negedge clk); pressed[0][3] = 1'b1;
    wait_valid("rsth_valid", 80, n);
    tick(3);
    @(negedge clk); reset = 1'b0;
    tick(1);
    check("rsth_key_held",  32'(kp.key_held),  32'd0);
    check("rsth_key_row",   32'(kp.key_row),   32'h0);
    check("rsth_key_col",   32'(kp.key_col),   32'h0);
    check("rsth_key_valid", 32'(kp.key_valid), 32'd0);
    check("rsth_row_drive", 32'(kp.row_drive), 32'h8);
    @(negedge clk); pressed = '0; reset = 1'b1;
    tick(4);

    // 40-cycle hold: repeat strobes at +16 and +32, none without repeat
    @(negedge clk); pressed[2][2] = 1'b1;
    wait_valid("hold_valid", 80, n);
    check("hold_key_col", 32'(kp.key_col), 32'h4);
    nrep = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (kp.key_valid) begin
        if (nrep < 2) off[nrep] = i;
        nrep++;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    check("rep_count", 32'(nrep), 32'd2);
    check("rep_off0", 32'(off[0]), 32'(REP));
    check("rep_off1", 32'(off[1]), 32'(2 * REP));
`else
    check("hold_single_strobe", 32'(nrep), 32'd0);
`endif
    check("hold_still_held", 32'(kp.key_held), 32'd1);
    release_key(2, 2, "hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Drives the 4x4 keypad row lines one-hot and samples the column lines.
- Debounces a single key and presents it as one-hot row/column codes plus a one-cycle `key_valid` strobe.
- Sits between the keypad pins and `key_decode`, whose `r`/`c` inputs take `key_row`/`key_col` directly.
- One key is owned at a time: other presses are locked out until the owned key is released and debounced.

## Interface
- `SCAN_DIV`, 4800: cycles each row is driven before its columns are sampled (≥2).
- `DEBOUNCE_CYCLES`, 240000: consecutive stable cycles required for press and release (≥1).
- `REPEAT_CYCLES`, 24000000: auto-repeat interval while held (≥1; used only with `KEYPAD_REPEAT_EN`).
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low; one clock; reset is synchronous and active-low.
- `col_in` in 4: raw, asynchronous column pins; active-high (external pull-downs); bit 0 = column 1.
- `row_drive` out 4: one-hot active-high row drive; 4'b1000 = row 1 … 4'b0001 = row 4.
- `key_row` out 4: one-hot row of the owned key; 0 when none.
- `key_col` out 4: one-hot column of the owned key; 0 when none.
- `key_valid` out 1: one-cycle strobe when a debounced press is accepted.
- `key_held` out 1: high from the `key_valid` cycle until release debounce completes.

## Operation
- `col_in` passes through a 2-flop synchronizer to give `col_s`. All decisions use `col_s`.
- `SCAN`:
  - `row_drive` rotates 1000→0100→0010→0001→1000.
  - Each row is held `SCAN_DIV` cycles by `div_cnt`.
  - `col_s` is sampled on the last cycle of the dwell (`div_cnt == SCAN_DIV-1`).
  - Exactly one bit set: latch `row_drive` into `lat_row` and `col_s` into `lat_col`, clear `deb_cnt`, freeze `row_drive`, go to `DEBOUNCE`.
  - Zero bits or ≥2 bits set: advance to the next row and stay in `SCAN`.
- `DEBOUNCE` (`row_drive` frozen):
  - `col_s == lat_col`: increment `deb_cnt`.
  - At `deb_cnt == DEBOUNCE_CYCLES-1` with a match: go to `HELD`, and `key_valid` = 1 for exactly that next cycle.
  - On `key_valid`, `key_row`/`key_col` load `lat_row`/`lat_col` and `key_held` = 1.
  - Any mismatch: go to `SCAN`, advance the row, no strobe.
- `HELD`:
  - Stay while `col_s & lat_col` is nonzero.
  - Other columns asserting is ignored (lockout).
  - When the owned column bit drops: clear `deb_cnt`, go to `RELEASE`.
- `RELEASE`:
  - Owned bit low: increment `deb_cnt`.
  - Owned bit returns high: back to `HELD`, no new strobe, `key_held` stays 1.
  - At `deb_cnt == DEBOUNCE_CYCLES-1` with the bit still low: go to `SCAN` and advance the row.
  - In that cycle, `key_held`, `key_row` and `key_col` clear to 0.
- Counter widths: `$clog2(param)` bits minimum. Counters never wrap past their terminal value.

## Timing
- Reset values: `row_drive` = 4'b1000, `key_row` = 0, `key_col` = 0, `key_valid` = 0, `key_held` = 0, state `SCAN`, all counters 0.
- `reset` low mid-operation overrides everything on the next edge. No strobe is emitted.
- Pin-to-latch latency: 2 cycles (synchronizer) plus the remainder of the current row dwell.
- Press latency: `key_valid` fires `DEBOUNCE_CYCLES` cycles after the latch cycle.
- `key_valid` is never high for two consecutive cycles.
- A press during `HELD`/`RELEASE` never produces a strobe. It is picked up in `SCAN` after release if still pressed.
- Release latency: `key_held` falls `DEBOUNCE_CYCLES` cycles after the owned bit first reads low in `col_s`.

## Configuration
- `KEYPAD_REPEAT_EN` defined: in `HELD`, `rep_cnt` counts from 0. At `REPEAT_CYCLES-1`, `key_valid` pulses one cycle (same `key_row`/`key_col`) and `rep_cnt` restarts. `rep_cnt` clears on entering `HELD` from `DEBOUNCE` or `RELEASE`.
- `KEYPAD_REPEAT_EN` undefined: exactly one `key_valid` per accepted press. `rep_cnt` is not synthesized.

## Structure
- `keypad_pkg`:
  - `typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t`
  - Row constants `ROW1`=4'b1000 … `ROW4`=4'b0001.
  - `function onehot4(logic [3:0])` → 1 if exactly one bit set.
- Sub-module `col_sync`: 4-bit, 2-flop synchronizer with `clk`/`reset` (reset value 0).
- `keypad_scanner` holds the FSM and counters.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8, `REPEAT_CYCLES`=16.
- Reset → `row_drive` = 1000, others 0. Idle 32 cycles → `row_drive` visits 0100, 0010, 0001, 1000 every 4 cycles.
- Row 2 / column 3 held clean → one `key_valid`, `key_row` = 0100, `key_col` = 0100. `key_decode` yields 4'b0110. Release → `key_held` falls 8 `col_s` cycles later.
- Bounce: column toggles every 3 cycles during `DEBOUNCE` → no `key_valid`, state returns to `SCAN`.
- Lockout: hold row 1/column 1, then also press row 4/column 2 → single strobe with `key_col` = 0001. After row 1 is released, row 4/column 2 is strobed (`key_row` 0001, `key_col` 0010).
- Two columns high on the same row (0011) → no latch, scan continues.
- `reset` low in `HELD`, and with `KEYPAD_REPEAT_EN` a 40-cycle hold → outputs cleared next edge. Repeat build gives strobes at +0, +16, +32 cycles after first `key_valid`.
